// File: rtl/game_flow_ctrl_pkg.sv
// Purpose: shared game constants, state encoding and court-geometry helpers
//   for the rally sequencer, the Ball datapath and the renderer.
package game_flow_ctrl_pkg;

  localparam int unsigned COORD_W   = 12;
  localparam int unsigned SCORE_W   = 4;

  localparam int unsigned BALL_W    = 30;
  localparam int unsigned BALL_H    = 30;
  localparam int unsigned FLOOR_Y   = 220;
  localparam int unsigned NET_POS_X = 160;
  localparam int unsigned NET_W     = 6;

  typedef enum logic [1:0] {
    ST_START     = 2'd0,
    ST_WAIT_DROP = 2'd1,
    ST_IN_GAME   = 2'd2,
    ST_GAME_END  = 2'd3
  } game_state_e;

  typedef enum logic {
    WIN_PLAYER = 1'b0,
    WIN_NPC    = 1'b1
  } winner_e;

  // Ball bottom edge touches the floor; sum stays in 12 bits on purpose.
  function automatic logic is_land(input logic [COORD_W-1:0] ball_y);
    return (ball_y + COORD_W'(BALL_H)) >= COORD_W'(FLOOR_Y);
  endfunction

  // Ball centre lies on the NPC (left) side of the net centre line.
  function automatic logic in_npc_court(input logic [COORD_W-1:0] ball_x);
    return (ball_x + COORD_W'(BALL_W / 2)) < COORD_W'(NET_POS_X + NET_W / 2);
  endfunction

endpackage

// File: rtl/game_flow_ctrl_if.sv
// Purpose: bundle between the input side (button, Ball position) and the
//   rally sequencer outputs (state, winner, scores, point strobe).
//   master: the sequencer; slave: the surrounding Ball/renderer/stimulus side.
interface game_flow_ctrl_if;
  import game_flow_ctrl_pkg::*;

  logic                 start_btn;
  logic [COORD_W-1:0]   Ball_X;
  logic [COORD_W-1:0]   Ball_Y;
  game_state_e          Game_state;
  logic                 who_win;
  logic [SCORE_W-1:0]   player_score;
  logic [SCORE_W-1:0]   npc_score;
  logic                 point_pulse;

  modport master (
    input  start_btn, Ball_X, Ball_Y,
    output Game_state, who_win, player_score, npc_score, point_pulse
  );

  modport slave (
    output start_btn, Ball_X, Ball_Y,
    input  Game_state, who_win, player_score, npc_score, point_pulse
  );

endinterface

// File: rtl/game_flow_ctrl_tick_gen.sv
// Purpose: free-running game tick generator, one-clk pulse every CLK_PER_TICK clks.
// Ports: clk, i_reset (sync, active-high), o_tick_c (decoded from the counter).
module game_flow_ctrl_tick_gen #(
  parameter int unsigned CLK_PER_TICK = 1_000_000
) (
  input  logic clk,
  input  logic i_reset,
  output logic o_tick_c
);

  localparam int unsigned CNT_W = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last   = (r_cnt == CNT_W'(CLK_PER_TICK - 1));
  assign o_tick_c = w_last;

  // Wrapping tick counter.
  always_ff @(posedge clk) begin
    if (i_reset)     r_cnt <= '0;
    else if (w_last) r_cnt <= '0;
    else             r_cnt <= r_cnt + CNT_W'(1);
  end

endmodule

// File: rtl/game_flow_ctrl.sv
// Purpose: rally sequencer. Runs START -> WAIT_DROP -> IN_GAME -> GAME_END,
//   awards a point on each floor landing and keeps both scores.
// Ports: clk, reset (sync, active-high), bus (master modport):
//   in  start_btn, Ball_X, Ball_Y
//   out Game_state, who_win, player_score, npc_score, point_pulse (all registered)
module game_flow_ctrl
  import game_flow_ctrl_pkg::*;
#(
  parameter int unsigned CLK_PER_TICK = 1_000_000,
  parameter int unsigned SERVE_TICKS  = 100,
  parameter int unsigned WIN_SCORE    = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  game_flow_ctrl_if.master        bus
);

  localparam int unsigned SERVE_W = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;

  game_state_e          r_state;
  logic                 r_who_win;
  logic [SCORE_W-1:0]   r_player_score;
  logic [SCORE_W-1:0]   r_npc_score;
  logic                 r_point_pulse;
  logic [SERVE_W-1:0]   r_serve_cnt;
  logic                 r_btn_prev;

  logic                 w_tick;
  logic                 w_btn_rise;
  logic                 w_land;
  logic                 w_npc_court;
  logic [SCORE_W-1:0]   w_player_inc;
  logic [SCORE_W-1:0]   w_npc_inc;

  game_flow_ctrl_tick_gen #(
    .CLK_PER_TICK (CLK_PER_TICK)
  ) u_tick_gen (
    .clk      (clk),
    .i_reset  (reset),
    .o_tick_c (w_tick)
  );

  // btn_prev resets high so a button held through reset never fires.
  assign w_btn_rise   = bus.start_btn & ~r_btn_prev;
  assign w_land       = is_land(bus.Ball_Y);
  assign w_npc_court  = in_npc_court(bus.Ball_X);
  assign w_player_inc = r_player_score + SCORE_W'(1);
  assign w_npc_inc    = r_npc_score + SCORE_W'(1);

  // Sequencer FSM with score datapath.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_START;
      r_who_win      <= WIN_PLAYER;
      r_player_score <= '0;
      r_npc_score    <= '0;
      r_point_pulse  <= 1'b0;
      r_serve_cnt    <= '0;
      r_btn_prev     <= 1'b1;
    end else begin
      r_btn_prev    <= bus.start_btn;
      r_point_pulse <= 1'b0;
      case (r_state)
        ST_START: begin
          if (w_btn_rise) begin
            r_state        <= ST_WAIT_DROP;
            r_player_score <= '0;
            r_npc_score    <= '0;
            r_serve_cnt    <= '0;
          end
        end
        ST_WAIT_DROP: begin
          if (w_tick) begin
            if (r_serve_cnt == SERVE_W'(SERVE_TICKS - 1)) r_state <= ST_IN_GAME;
            else                                           r_serve_cnt <= r_serve_cnt + SERVE_W'(1);
          end
        end
        ST_IN_GAME: begin
          // Leaving IN_GAME on this edge is what limits a landing to one point.
          if (w_land) begin
            r_point_pulse <= 1'b1;
            r_serve_cnt   <= '0;
            if (w_npc_court) begin
              r_who_win <= WIN_PLAYER;
              if (r_player_score < SCORE_W'(WIN_SCORE)) r_player_score <= w_player_inc;
              r_state <= (w_player_inc == SCORE_W'(WIN_SCORE)) ? ST_GAME_END : ST_WAIT_DROP;
            end else begin
              r_who_win <= WIN_NPC;
              if (r_npc_score < SCORE_W'(WIN_SCORE)) r_npc_score <= w_npc_inc;
              r_state <= (w_npc_inc == SCORE_W'(WIN_SCORE)) ? ST_GAME_END : ST_WAIT_DROP;
            end
          end
        end
        ST_GAME_END: begin
          // Scores stay visible until the next serve starts.
          if (w_btn_rise) r_state <= ST_START;
        end
        default: r_state <= ST_START;
      endcase
    end
  end

  assign bus.Game_state   = r_state;
  assign bus.who_win      = r_who_win;
  assign bus.player_score = r_player_score;
  assign bus.npc_score    = r_npc_score;
  assign bus.point_pulse  = r_point_pulse;

endmodule
